// File: rtl/pps_pkg.sv
// pps_pkg: shared state encoding, period width and tolerance helper for pps_capture.
package pps_pkg;

    localparam int PERIOD_W = 32;

    typedef enum logic {
        SEARCH,
        TRACK
    } state_t;

    // Subtract in whichever direction cannot wrap before comparing.
    function automatic logic in_tol(
        input logic [PERIOD_W-1:0] period,
        input logic [PERIOD_W-1:0] nominal,
        input logic [PERIOD_W-1:0] tol
    );
        return ((period >= nominal) ? period - nominal : nominal - period) <= tol;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// pps_edge_sync: two-flop synchronizer plus registered rising-edge detector, one-cycle pulse out.
module pps_edge_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_pulse
);

    logic [1:0] sync_q;
    logic [1:0] live_q;
    logic       prev_q;
    logic       armed_q;
    logic       pulse_q;

    // Edges are only armed after a genuine low has been synchronized, so an
    // input held high through reset release does not look like a rising edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q  <= '0;
            live_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_async};
            live_q  <= {live_q[0], 1'b1};
            prev_q  <= sync_q[1];
            armed_q <= armed_q | (live_q[1] & ~sync_q[1]);
            pulse_q <= armed_q & sync_q[1] & ~prev_q;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/pps_capture.sv
// pps_capture: measures i_clk cycles between PPS rising edges, reports lock and timeout.
module pps_capture
    import pps_pkg::*;
#(
    parameter int unsigned CLOCK_RATE_HZ    = 12_000_000,
    parameter int unsigned TOLERANCE_CLOCKS = CLOCK_RATE_HZ / 1000,
    parameter int unsigned TIMEOUT_CLOCKS   = 2 * CLOCK_RATE_HZ
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_pps,
    output logic                o_valid,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_locked,
    output logic                o_lost,
    output logic                o_led
);

    logic                edge_w;
    logic [PERIOD_W-1:0] period_n;
    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                lost_q, lost_d;
    logic                locked_q, locked_d;

    pps_edge_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_pps),
        .o_pulse (edge_w)
    );

    assign period_n = cnt_q + 1;

    // An edge outranks a coincident timeout, so a period of exactly TIMEOUT_CLOCKS is reported.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        period_d = period_q;
        valid_d  = 1'b0;
        lost_d   = 1'b0;
        locked_d = locked_q;
        if (state_q == SEARCH) begin
            if (edge_w) state_d = TRACK;
        end else if (edge_w) begin
            period_d = period_n;
            valid_d  = 1'b1;
            locked_d = in_tol(period_n, PERIOD_W'(CLOCK_RATE_HZ), PERIOD_W'(TOLERANCE_CLOCKS));
        end else if (cnt_q == PERIOD_W'(TIMEOUT_CLOCKS - 1)) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            state_d  = SEARCH;
        end else begin
            cnt_d = cnt_q + 1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            lost_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
            locked_q <= locked_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_period = period_q;
    assign o_locked = locked_q;
    assign o_lost   = lost_q;
    assign o_led    = locked_q;

endmodule

// File: tb/tb_pps_capture.sv
// tb_pps_capture: scoreboard bench for pps_capture with CLOCK_RATE_HZ=1000, TOLERANCE=10, TIMEOUT=2000.
module tb_pps_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pps = 1'b0;
    logic        o_valid;
    logic [31:0] o_period;
    logic        o_locked;
    logic        o_lost;
    logic        o_led;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_k     = 0;

    typedef struct {
        int c;
        int p;
        bit l;
    } exp_t;

    exp_t vq[$];
    int   lq[$];

    pps_capture #(
        .CLOCK_RATE_HZ    (1000),
        .TOLERANCE_CLOCKS (10),
        .TIMEOUT_CLOCKS   (2000)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_pps    (pps),
        .o_valid  (o_valid),
        .o_period (o_period),
        .o_locked (o_locked),
        .o_lost   (o_lost),
        .o_led    (o_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic bit lock_of(input int p);
        return (p >= 990) && (p <= 1010);
    endfunction

    // Scoreboard: compares every reported period / lost strobe with the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (vq.size() != 0 && vq[0].c < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL valid_missing: expected at cycle %0d, no o_valid by cycle %0d", vq[0].c, cyc);
            vq.delete(0);
        end
        if (lq.size() != 0 && lq[0] < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL lost_missing: expected at cycle %0d, no o_lost by cycle %0d", lq[0], cyc);
            lq.delete(0);
        end
        if (o_valid) begin
            compared++;
            if (vq.size() == 0) begin
                mismatched++;
                $display("FAIL valid_unexpected: cycle %0d period %0d, required no o_valid", cyc, o_period);
            end else begin
                e = vq.pop_front();
                if (cyc !== e.c || o_period !== e.p || o_locked !== e.l) begin
                    mismatched++;
                    $display("FAIL valid_report: got cycle %0d period %0d locked %0b, required cycle %0d period %0d locked %0b",
                             cyc, o_period, o_locked, e.c, e.p, e.l);
                end
            end
            compared++;
            if (o_led !== o_locked || o_lost !== 1'b0) begin
                mismatched++;
                $display("FAIL valid_side: led %0b lost %0b, required led %0b lost 0", o_led, o_lost, o_locked);
            end
        end
        if (o_lost) begin
            compared++;
            if (lq.size() == 0) begin
                mismatched++;
                $display("FAIL lost_unexpected: cycle %0d, required no o_lost", cyc);
            end else if (cyc !== lq[0] || o_locked !== 1'b0) begin
                mismatched++;
                $display("FAIL lost_report: got cycle %0d locked %0b, required cycle %0d locked 0", cyc, o_locked, lq[0]);
                lq.delete(0);
            end else begin
                lq.delete(0);
            end
        end
    end

    task automatic pulse(input int spacing, input bit first);
        if (first) @(negedge clk);
        else while (cyc + 1 < last_k + spacing) @(negedge clk);
        last_k = cyc + 1;
        pps = 1'b1;
        if (!first) vq.push_back('{last_k + 3, spacing, lock_of(spacing)});
        repeat (5) @(negedge clk);
        pps = 1'b0;
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (vq.size() != 0 || lq.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drained: %0d valid / %0d lost pending, required 0 / 0", name, vq.size(), lq.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pps = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({o_valid, o_lost, o_locked, o_led} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b, required 0000", {o_valid, o_lost, o_locked, o_led});
        end
        compared++;
        if (o_period !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_period: got %0d, required 0", o_period);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_lock;
        pulse(0, 1'b1);
        repeat (3) pulse(1000, 1'b0);
        repeat (5) @(negedge clk);
        check_drained("lock");
        compared++;
        if (o_locked !== 1'b1 || o_led !== 1'b1 || o_period !== 32'd1000) begin
            mismatched++;
            $display("FAIL lock_state: locked %0b led %0b period %0d, required 1 1 1000", o_locked, o_led, o_period);
        end
    endtask

    task automatic test_tolerance;
        pulse(1020, 1'b0);
        pulse(1005, 1'b0);
        pulse(1010, 1'b0);
        pulse(1011, 1'b0);
        pulse(990, 1'b0);
        pulse(989, 1'b0);
        repeat (5) @(negedge clk);
        check_drained("tolerance");
        compared++;
        if (o_locked !== 1'b0 || o_period !== 32'd989) begin
            mismatched++;
            $display("FAIL tolerance_state: locked %0b period %0d, required 0 989", o_locked, o_period);
        end
    endtask

    task automatic test_timeout;
        pulse(1000, 1'b0);
        lq.push_back(last_k + 2003);
        while (cyc < last_k + 2010) @(negedge clk);
        check_drained("timeout");
        compared++;
        if (o_locked !== 1'b0 || o_led !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_locked: locked %0b led %0b, required 0 0", o_locked, o_led);
        end
        compared++;
        if (o_period !== 32'd1000) begin
            mismatched++;
            $display("FAIL timeout_period: got %0d, required 1000", o_period);
        end
        pulse(0, 1'b1);
        pulse(1000, 1'b0);
        repeat (5) @(negedge clk);
        check_drained("relock");
    endtask

    task automatic test_coincide;
        pulse(2000, 1'b0);
        repeat (10) @(negedge clk);
        check_drained("coincide");
        compared++;
        if (o_period !== 32'd2000 || o_locked !== 1'b0) begin
            mismatched++;
            $display("FAIL coincide_state: period %0d locked %0b, required 2000 0", o_period, o_locked);
        end
    endtask

    task automatic test_reset_mid;
        pulse(1000, 1'b0);
        while (cyc < last_k + 503) @(negedge clk);
        rst = 1'b1;
        #1;
        compared++;
        if ({o_valid, o_lost, o_locked, o_led} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_mid_flags: got %b, required 0000", {o_valid, o_lost, o_locked, o_led});
        end
        compared++;
        if (o_period !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_mid_period: got %0d, required 0", o_period);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        pulse(0, 1'b1);
        pulse(1234, 1'b0);
        repeat (5) @(negedge clk);
        check_drained("reset_mid");
    endtask

    task automatic test_pps_high_reset;
        rst = 1'b1;
        pps = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        compared++;
        if (o_valid !== 1'b0 || o_locked !== 1'b0 || o_period !== 32'd0) begin
            mismatched++;
            $display("FAIL high_reset_idle: valid %0b locked %0b period %0d, required 0 0 0", o_valid, o_locked, o_period);
        end
        pps = 1'b0;
        repeat (5) @(negedge clk);
        pulse(0, 1'b1);
        pulse(1000, 1'b0);
        repeat (5) @(negedge clk);
        check_drained("high_reset");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_pps_high_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/pps_capture.md
PPS_CAPTURE -- requirements
Module: pps_capture

Interface
REQ-001 SHALL have parameter CLOCK_RATE_HZ, default 12_000_000, meaning the nominal i_clk cycles per second.
REQ-002 SHALL have parameter TOLERANCE_CLOCKS, default CLOCK_RATE_HZ/1000, meaning the allowed ± deviation of a measured period for lock.
REQ-003 SHALL have parameter TIMEOUT_CLOCKS, default 2*CLOCK_RATE_HZ, meaning the cycles without an edge before lock is declared lost.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic in this one domain.
REQ-005 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port i_pps, input, 1 bit: external pulse-per-second, asynchronous to i_clk.
REQ-007 SHALL have port o_valid, output, 1 bit: one-cycle strobe, new o_period available.
REQ-008 SHALL have port o_period, output, 32 bits: i_clk cycles between the last two detected rising edges.
REQ-009 SHALL have port o_locked, output, 1 bit: high while the last period is within tolerance and no timeout has occurred.
REQ-010 SHALL have port o_lost, output, 1 bit: one-cycle strobe on timeout.
REQ-011 SHALL have port o_led, output, 1 bit: equal to o_locked.

Function
REQ-012 SHALL pass i_pps through a two-flop synchronizer, then a registered rising-edge detector (high sync output, low previous).
REQ-013 SHALL assert o_valid for a period-reporting edge exactly 3 cycles after the first i_clk edge that samples i_pps high.
REQ-014 SHALL have states SEARCH (no reference edge) and TRACK (reference edge held).
REQ-015 SHALL, in SEARCH on a detected edge: clear the counter, enter TRACK, and leave o_valid low.
REQ-016 SHALL, in TRACK on a detected edge: load o_period with counter+1, pulse o_valid, clear the counter, and stay in TRACK.
REQ-017 SHALL ensure that detected edges at cycles t0 and t1 yield o_period = t1 - t0.
REQ-018 SHALL set o_locked together with o_valid, to 1 iff |o_period - CLOCK_RATE_HZ| <= TOLERANCE_CLOCKS, else 0.
REQ-019 SHALL keep reporting out-of-tolerance periods normally; they only clear o_locked.
REQ-020 SHALL increment the counter every non-edge cycle in TRACK; the counter SHALL stay 0 in SEARCH.
REQ-021 SHALL, when the counter reaches TIMEOUT_CLOCKS-1 with no edge in TRACK: pulse o_lost, clear o_locked, clear the counter, and enter SEARCH.
REQ-022 SHALL hold o_period across timeout; it changes only on o_valid.
REQ-023 SHALL, when an edge and timeout coincide in the same cycle, take the edge (REQ-016) and suppress o_lost.
REQ-024 SHALL perform all arithmetic unsigned, 32-bit; the tolerance compare SHALL not wrap (compute the difference in the correct direction).
REQ-025 SHALL register all outputs; o_valid and o_lost are never high in the same cycle.

Reset
REQ-026 SHALL, on i_reset asserted: synchronizer and edge flops = 0, state = SEARCH, counter = 0, o_period = 0, o_valid = o_lost = o_locked = o_led = 0.
REQ-027 SHALL, on reset mid-measurement, discard the partial count; the first post-reset edge SHALL be treated as SEARCH.
REQ-028 SHALL ensure that i_pps held high through reset release produces no edge until it goes low and then high.

Structure
REQ-029 SHALL place the state encoding and the 32-bit period width constant in shared package pps_pkg.
REQ-030 SHALL contain one sub-module, pps_edge_sync (synchronizer + rising-edge detector, output 1-cycle pulse).

Verification
Benches SHALL use CLOCK_RATE_HZ=1000, TOLERANCE_CLOCKS=10, TIMEOUT_CLOCKS=2000.
REQ-031 SHALL test: i_pps rising every 1000 cycles, 4 pulses -> no o_valid on the 1st; o_valid with o_period=1000 and o_locked=1 on the 2nd–4th, each 3 cycles after sampling.
REQ-032 SHALL test: pulse spacing 1000 then 1020 -> o_period=1020, o_locked=0; a following spacing of 1005 -> o_locked=1.
REQ-033 SHALL test: lock, then no pulse for 2000 cycles -> single o_lost strobe, o_locked=0, o_period still 1000; the next pulse produces no o_valid.
REQ-034 SHALL test: pulse arriving so its detected edge coincides with the timeout cycle -> o_valid with o_period=2000, no o_lost.
REQ-035 SHALL test: i_reset asserted 500 cycles after an edge -> all outputs 0 immediately; the next pulse produces no o_valid; the following pulse reports its true spacing.
REQ-036 SHALL test: i_pps high across reset release -> no o_valid or state change until a low-to-high transition.
